fifo_nibble_tx: RTL and testbench

- Drain side of the 4-bit, 16-deep linear FIFO.
- Pops one nibble whenever the FIFO is non-empty and transmission is enabled.
- Serialises each nibble onto a single UART-style line: start bit, 4 data bits LSB first, optional even parity, stop bit.
- Sits between the FIFO's read port and the board-level serial pin.

---
 rtl/fifo_nibble_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_nibble_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_nibble_tx.sv
// Drain side of the nibble FIFO: pops one 4-bit entry per frame and serialises it
// as start, 4 data bits LSB first, optional even parity, stop.
module fifo_nibble_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [1:0] bit_q, bit_d;
  logic [3:0] sh_q, sh_d;
  logic       par_q, par_d;
  logic       rd_q, rd_d;
  logic [7:0] cnt_q, cnt_d;
  logic       bit_end;
  logic       start_ok;

  assign bit_end  = (baud_q == BAUD_MAX);
  assign start_ok = enable & ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    rd_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = POP;
          rd_d    = 1'b1;
        end
      end
      POP: state_d = LOAD;
      // The FIFO accepted the pop on the previous edge, so its data is valid now.
      LOAD: begin
        sh_d    = fifo_data;
        par_d   = ^fifo_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[3:1]};
          if (bit_q == 2'd3) begin
            bit_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 2'd1;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          cnt_d  = cnt_q + 8'd1;
          // Chaining straight into POP gives the minimum two-cycle inter-frame gap.
          if (start_ok) begin
            state_d = POP;
            rd_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sh_q[0];
      PARITY:  tx = par_q;
      default: tx = 1'b1;
    endcase
  end

  assign fifo_rd_en  = rd_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == STOP) && bit_end;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Bench for fifo_nibble_tx: parity and no-parity instances share one FIFO model;
// a line monitor decodes frames and the main sequence scores them against expectations.
module tb_fifo_nibble_tx;

  localparam int CPB = 4;

  typedef struct {
    logic       sel;
    logic [3:0] nib;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    logic [6:0] bits;
    bit         glitch;
    bit         done_ok;
    int         gap;
  } got_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       sel = 1'b0;
  logic       fifo_empty;
  logic [3:0] fifo_data = '0;
  logic       en_p, en_n;
  logic       rd_p, tx_p, busy_p, done_p;
  logic       rd_n, tx_n, busy_n, done_n;
  logic [7:0] fc_p, fc_n;
  logic       m_tx, m_rd, m_done;

  always #5 clk = ~clk;

  assign en_p   = en & ~sel;
  assign en_n   = en & sel;
  assign m_tx   = sel ? tx_n : tx_p;
  assign m_rd   = sel ? rd_n : rd_p;
  assign m_done = sel ? done_n : done_p;

  fifo_nibble_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .enable(en_p), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_p), .tx(tx_p), .busy(busy_p), .frame_done(done_p), .frame_count(fc_p));

  fifo_nibble_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .enable(en_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd_n), .tx(tx_n), .busy(busy_n), .frame_done(done_n), .frame_count(fc_n));

  // FIFO model: data appears the cycle after the pop edge
  logic [3:0] mem [512];
  int wr_ptr = 0, rd_ptr = 0, pops = 0, bad_pops = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial begin : fifo_model
    forever begin
      @(posedge clk);
      if (m_rd === 1'b1) begin
        if (wr_ptr == rd_ptr) bad_pops <= bad_pops + 1;
        else begin
          fifo_data <= mem[rd_ptr % 512];
          rd_ptr    <= rd_ptr + 1;
        end
        pops <= pops + 1;
      end
    end
  end

  // Line monitor: frame starts at the first low sample, bits sampled per cycle
  got_t got [$];
  initial begin : monitor
    int cyc, len, idle_run, b;
    bit infr, dn_early;
    got_t g;
    infr = 1'b0; idle_run = 999; cyc = 0; len = 0; dn_early = 1'b0;
    g.bits = '0; g.glitch = 1'b0; g.done_ok = 1'b0; g.gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        infr = 1'b0; idle_run = 999;
      end else begin
        if (!infr) begin
          if (m_tx === 1'b0) begin
            infr = 1'b1; cyc = 1; len = (sel ? 6 : 7) * CPB;
            g.bits = '0; g.glitch = 1'b0; g.gap = idle_run; dn_early = 1'b0;
          end else idle_run++;
        end else cyc++;
        if (infr) begin
          b = (cyc - 1) / CPB;
          if ((cyc - 1) % CPB == 0) g.bits[b] = m_tx;
          else if (m_tx !== g.bits[b]) g.glitch = 1'b1;
          if (cyc < len) begin
            if (m_done !== 1'b0) dn_early = 1'b1;
          end else begin
            g.done_ok = (m_done === 1'b1) && !dn_early;
            got.push_back(g);
            infr = 1'b0; idle_run = 0;
          end
        end
      end
    end
  end

  int errors = 0, checks = 0, rdp = 0;
  logic [6:0] sb [$];
  vec_t tv [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] nib, input logic [6:0] exp);
    mem[wr_ptr % 512] = nib;
    wr_ptr++;
    sb.push_back(exp);
  endtask

  task automatic cmp_frame(input string nm, output int gap);
    int n;
    logic [6:0] e;
    got_t g;
    gap = -1;
    n = 0;
    while (got.size() <= rdp && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (got.size() <= rdp || sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no frame expected one", nm);
    end else begin
      g = got[rdp];
      rdp++;
      e = sb.pop_front();
      gap = g.gap;
      chk({nm, "_bits"}, 32'(g.bits), 32'(e));
      chk({nm, "_done"}, 32'(g.done_ok), 32'd1);
      chk({nm, "_width"}, 32'(g.glitch), 32'd0);
    end
  endtask

  initial begin
    int bad, p0, c0, gap;
    logic [6:0] junk;
    // bit i = line level during bit i of the frame (start first)
    tv[0] = '{1'b0, 4'hB, 7'b1110110};
    tv[1] = '{1'b0, 4'h0, 7'b1000000};
    tv[2] = '{1'b0, 4'h7, 7'b1101110};
    tv[3] = '{1'b1, 4'h3, 7'b0100110};
    tv[4] = '{1'b1, 4'h8, 7'b0110000};
    tv[5] = '{1'b1, 4'hF, 7'b0111110};

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_p), 32'd1);
    chk("rst_busy", 32'(busy_p), 32'd0);
    chk("rst_rd", 32'(rd_p), 32'd0);
    chk("rst_done", 32'(done_p), 32'd0);
    chk("rst_fc", 32'(fc_p), 32'd0);
    rst = 1'b0;

    en = 1'b1; bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_p !== 1'b1 || busy_p !== 1'b0 || rd_p !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("idle_pops", 32'(pops), 32'd0);
    chk("idle_fc", 32'(fc_p), 32'd0);

    for (int i = 0; i < 3; i++) begin
      sel = tv[i].sel;
      p0 = pops;
      push(tv[i].nib, tv[i].exp);
      cmp_frame($sformatf("par%0d", i), gap);
      @(negedge clk);
      chk("par_one_pop", 32'(pops - p0), 32'd1);
      chk("par_fc", 32'(fc_p), 32'(i + 1));
    end

    // back-to-back frames without parity
    sel = 1'b1;
    p0 = pops;
    for (int i = 3; i < 6; i++) push(tv[i].nib, tv[i].exp);
    for (int i = 3; i < 6; i++) begin
      cmp_frame($sformatf("b2b%0d", i), gap);
      if (i > 3) chk("b2b_gap", 32'(gap), 32'd2);
    end
    @(negedge clk);
    chk("b2b_fc", 32'(fc_n), 32'd3);
    chk("b2b_empty", 32'(fifo_empty), 32'd1);
    chk("b2b_pops", 32'(pops - p0), 32'd3);
    sel = 1'b0;

    // enable dropped mid-DATA with two nibbles queued
    c0 = fc_p; p0 = pops;
    push(4'h7, 7'b1101110);
    push(4'h0, 7'b1000000);
    repeat (12) @(negedge clk);
    en = 1'b0;
    cmp_frame("endrop1", gap);
    repeat (20) @(negedge clk);
    chk("endrop_no_frame", 32'(got.size()), 32'(rdp));
    chk("endrop_idle", 32'(busy_p), 32'd0);
    chk("endrop_kept", 32'(fifo_empty), 32'd0);
    chk("endrop_pops", 32'(pops - p0), 32'd1);
    en = 1'b1;
    cmp_frame("endrop2", gap);
    @(negedge clk);
    chk("endrop_fc", 32'(fc_p - c0), 32'd2);

    // asynchronous reset mid-DATA
    push(4'hB, 7'b1110110);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", 32'(tx_p), 32'd1);
    chk("arst_busy", 32'(busy_p), 32'd0);
    chk("arst_fc", 32'(fc_p), 32'd0);
    junk = sb.pop_front();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(4'h7, 7'b1101110);
    cmp_frame("arst_fresh", gap);
    @(negedge clk);
    chk("arst_fc_after", 32'(fc_p), 32'd1);

    // 256 frames of 0x5: parity stays 0, counter wraps
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 256; i++) push(4'h5, 7'b1001010);
    for (int i = 0; i < 256; i++) begin
      cmp_frame("wrap", gap);
      if (i == 254) begin
        @(negedge clk);
        chk("wrap_fc255", 32'(fc_p), 32'd255);
      end
    end
    @(negedge clk);
    chk("wrap_fc0", 32'(fc_p), 32'd0);
    chk("wrap_empty", 32'(fifo_empty), 32'd1);
    chk("no_bad_pops", 32'(bad_pops), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
